// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: turns UART command bytes into single 8-bit Wishbone cycles
// and returns one response byte per completed read, write or ack timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a command header {rw, adr[6:0]}
// GET_DATA | write header seen, waiting for the data byte (byte timer)
// WB_CYCLE | stb/cyc asserted, waiting for wb_ack_i (ack timer)
// RESP     | tx_valid held with a constant tx_data until tx_ready

`timescale 1ns/1ps

module uart_wb_bridge #(
  parameter logic [15:0] ACK_TIMEOUT  = 16'd255,
  parameter logic [15:0] BYTE_TIMEOUT = 16'd4095,
  parameter bit          WR_RESP      = 1'b1,
  parameter logic [7:0]  WR_OK_BYTE   = 8'h00,
  parameter logic [7:0]  ERR_BYTE     = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [6:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_DATA = 2'd1,
    WB_CYCLE = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] byte_timer;
  logic [15:0] ack_timer;
  logic [15:0] byte_timer_nxt;
  logic [15:0] ack_timer_nxt;

  // Saturating increments: the timers stop at all-ones instead of wrapping.
  always_comb begin
    byte_timer_nxt = (byte_timer == 16'hFFFF) ? byte_timer : byte_timer + 16'd1;
    ack_timer_nxt  = (ack_timer  == 16'hFFFF) ? ack_timer  : ack_timer  + 16'd1;
  end

  // Command sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_timer <= 16'd0;
      ack_timer  <= 16'd0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      wb_adr_o   <= 7'd0;
      wb_dat_o   <= 8'd0;
      wb_we_o    <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            wb_adr_o <= rx_data[6:0];
            wb_we_o  <= rx_data[7];
            if (rx_data[7]) begin
              byte_timer <= 16'd0;
              state      <= GET_DATA;
            end else begin
              // Strobe rises together with the state change so a one-cycle
              // ack slave completes two edges after the header.
              ack_timer <= 16'd0;
              wb_stb_o  <= 1'b1;
              wb_cyc_o  <= 1'b1;
              state     <= WB_CYCLE;
            end
          end
        end

        GET_DATA: begin
          if (rx_valid) begin
            wb_dat_o  <= rx_data;
            ack_timer <= 16'd0;
            wb_stb_o  <= 1'b1;
            wb_cyc_o  <= 1'b1;
            state     <= WB_CYCLE;
          end else if (byte_timer_nxt >= BYTE_TIMEOUT) begin
            // Data byte never came: drop the command silently.
            byte_timer <= 16'd0;
            state      <= IDLE;
          end else begin
            byte_timer <= byte_timer_nxt;
          end
        end

        WB_CYCLE: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            if (!wb_we_o) begin
              tx_data  <= wb_dat_i;
              tx_valid <= 1'b1;
              state    <= RESP;
            end else if (WR_RESP) begin
              tx_data  <= WR_OK_BYTE;
              tx_valid <= 1'b1;
              state    <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (ack_timer_nxt >= ACK_TIMEOUT) begin
            // Slave is unresponsive: abandon the cycle and report it.
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            tx_data  <= ERR_BYTE;
            tx_valid <= 1'b1;
            state    <= RESP;
          end else begin
            ack_timer <= ack_timer_nxt;
          end
        end

        RESP: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge with a one-cycle-ack csr slave model.

`timescale 1ns/1ps

module tb_uart_wb_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [6:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  uart_wb_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_ack_i (wb_ack_i),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // csr slave model: ack one cycle after it sees stb, write on that edge.
  logic [7:0] mem [0:127];
  logic       ack_en = 1'b1;
  logic       ack_q;
  assign wb_ack_i = ack_q;
  assign wb_dat_i = mem[wb_adr_o];

  always @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= wb_cyc_o && wb_stb_o && !ack_q && ack_en;
      if (wb_cyc_o && wb_stb_o && !ack_q && ack_en && wb_we_o)
        mem[wb_adr_o] <= wb_dat_o;
    end
  end

  // Bus / TX monitor.
  int         stb_cycles = 0;
  int         stb_starts = 0;
  int         tx_cnt     = 0;
  int         cyc_err    = 0;
  logic [7:0] last_tx    = 8'd0;
  logic [6:0] mon_adr    = 7'd0;
  logic       mon_we     = 1'b0;
  logic [7:0] mon_dat    = 8'd0;
  logic       stb_q      = 1'b0;

  always @(posedge clk) begin
    if (wb_cyc_o !== wb_stb_o) cyc_err++;
    if (wb_stb_o) begin
      stb_cycles++;
      mon_adr = wb_adr_o;
      mon_we  = wb_we_o;
      mon_dat = wb_dat_o;
      if (!stb_q) stb_starts++;
    end
    stb_q = wb_stb_o;
    if (tx_valid && tx_ready) begin
      tx_cnt++;
      last_tx = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int prev, input string name);
    int n;
    n = 0;
    while (tx_cnt == prev && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_cnt == prev) begin
      bad++;
      $display("FAIL %s: no tx response within %0d cycles", name, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, overrun} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, overrun});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read;
    int s0, c0, t0;
    s0 = stb_starts; c0 = stb_cycles; t0 = tx_cnt;
    send_byte(8'h03);
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 7'd3 || wb_we_o !== 1'b0) begin
      bad++;
      $display("FAIL read_stb_rise: stb=%b adr=%h we=%b want 1 03 0", wb_stb_o, wb_adr_o, wb_we_o);
    end
    @(negedge clk);
    total++;
    if (wb_stb_o !== 1'b1 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_mid: stb=%b tx_valid=%b want 1 0", wb_stb_o, tx_valid);
    end
    @(negedge clk);
    total++;
    if (wb_stb_o !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
      bad++;
      $display("FAIL read_resp: stb=%b tx_valid=%b tx_data=%h want 0 1 5a", wb_stb_o, tx_valid, tx_data);
    end
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0 || tx_cnt - t0 != 1 || last_tx !== 8'h5A) begin
      bad++;
      $display("FAIL read_tx: tx_valid=%b count=%0d byte=%h want 0 1 5a", tx_valid, tx_cnt - t0, last_tx);
    end
    total++;
    if (stb_starts - s0 != 1 || stb_cycles - c0 != 2) begin
      bad++;
      $display("FAIL read_stb_shape: pulses=%0d cycles=%0d want 1 2", stb_starts - s0, stb_cycles - c0);
    end
  endtask

  task automatic test_write;
    int t0;
    t0 = tx_cnt;
    send_byte(8'h81);
    send_byte(8'h37);
    wait_tx(t0, "write_resp_wait");
    total++;
    if (mon_adr !== 7'd1 || mon_we !== 1'b1 || mon_dat !== 8'h37 || mem[1] !== 8'h37) begin
      bad++;
      $display("FAIL write_cycle: adr=%h we=%b dat=%h mem=%h want 01 1 37 37", mon_adr, mon_we, mon_dat, mem[1]);
    end
    total++;
    if (last_tx !== 8'h00) begin
      bad++;
      $display("FAIL write_resp: got %h want 00", last_tx);
    end
    t0 = tx_cnt;
    send_byte(8'h01);
    wait_tx(t0, "readback_wait");
    total++;
    if (last_tx !== 8'h37) begin
      bad++;
      $display("FAIL readback: got %h want 37", last_tx);
    end
  endtask

  task automatic test_ack_timeout;
    int n, t0;
    ack_en = 1'b0;
    t0 = tx_cnt;
    send_byte(8'h05);
    n = 0;
    while (wb_stb_o === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 255) begin
      bad++;
      $display("FAIL ack_timeout_len: stb high %0d cycles want 255", n);
    end
    wait_tx(t0, "ack_timeout_wait");
    total++;
    if (last_tx !== 8'hEE) begin
      bad++;
      $display("FAIL ack_timeout_resp: got %h want ee", last_tx);
    end
    ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_byte_timeout;
    int s0, t0;
    // Data arriving well inside the window is still accepted.
    t0 = tx_cnt;
    send_byte(8'h82);
    repeat (4000) @(negedge clk);
    send_byte(8'h11);
    wait_tx(t0, "late_data_wait");
    total++;
    if (mem[2] !== 8'h11 || last_tx !== 8'h00) begin
      bad++;
      $display("FAIL late_data_write: mem=%h resp=%h want 11 00", mem[2], last_tx);
    end
    // Data never arrives: the command is dropped without bus or tx activity.
    s0 = stb_starts; t0 = tx_cnt;
    send_byte(8'h82);
    repeat (4100) @(negedge clk);
    total++;
    if (stb_starts != s0 || tx_cnt != t0) begin
      bad++;
      $display("FAIL byte_timeout_quiet: pulses=%0d tx=%0d want 0 0", stb_starts - s0, tx_cnt - t0);
    end
    send_byte(8'h04);
    wait_tx(t0, "after_timeout_wait");
    total++;
    if (mon_we !== 1'b0 || mon_adr !== 7'd4 || last_tx !== 8'hC4 || mem[2] !== 8'h11) begin
      bad++;
      $display("FAIL after_timeout_read: we=%b adr=%h tx=%h mem2=%h want 0 04 c4 11",
               mon_we, mon_adr, last_tx, mem[2]);
    end
  endtask

  task automatic test_backpressure;
    int n, t0, s0, unstable;
    tx_ready = 1'b0;
    t0 = tx_cnt; s0 = stb_starts;
    send_byte(8'h03);
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    send_byte(8'h10);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A) unstable++;
    end
    total++;
    if (unstable != 0 || tx_cnt != t0) begin
      bad++;
      $display("FAIL backpressure_hold: unstable=%0d tx=%0d want 0 0", unstable, tx_cnt - t0);
    end
    tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (tx_cnt - t0 != 1 || last_tx !== 8'h5A || tx_valid !== 1'b0 || stb_starts - s0 != 1) begin
      bad++;
      $display("FAIL backpressure_release: tx=%0d byte=%h valid=%b pulses=%0d want 1 5a 0 1",
               tx_cnt - t0, last_tx, tx_valid, stb_starts - s0);
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid_cycle;
    int t0;
    ack_en = 1'b0;
    send_byte(8'h06);
    total++;
    if (wb_stb_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_pre: stb=%b want 1", wb_stb_o);
    end
    t0 = tx_cnt;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({wb_stb_o, wb_cyc_o, tx_valid, overrun} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset: stb,cyc,tx_valid,overrun=%b want 0000",
               {wb_stb_o, wb_cyc_o, tx_valid, overrun});
    end
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h03);
    wait_tx(t0, "post_reset_wait");
    repeat (3) @(negedge clk);
    total++;
    if (tx_cnt - t0 != 1 || last_tx !== 8'h5A) begin
      bad++;
      $display("FAIL post_reset_read: tx=%0d byte=%h want 1 5a", tx_cnt - t0, last_tx);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[3] = 8'h5A;
    mem[4] = 8'hC4;
    test_reset();
    test_read();
    test_write();
    test_ack_timeout();
    test_byte_timeout();
    test_backpressure();
    test_reset_mid_cycle();
    total++;
    if (cyc_err != 0) begin
      bad++;
      $display("FAIL cyc_eq_stb: %0d cycles differ want 0", cyc_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
